// File: rtl/list_walker_pkg.sv
// Shared constants and state encoding for list_walker: memory_unit widths and
// function codes, the NIL address and the walk FSM states.
package list_walker_pkg;

  localparam int unsigned MemoryAddrWidth = 10;
  localparam int unsigned MemoryDataWidth = 20;
  localparam logic [1:0]  GetContents     = 2'd1;

  localparam int unsigned Nil = 0;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StEmit,
    StDone
  } walk_state_e;

endpackage

// File: rtl/list_walker.sv
// Linked-list traversal engine driving memory_unit's request port and streaming cell values.
// Optional WAIT timeout (err_timeout port, TIMEOUT parameter) under LIST_WALKER_TIMEOUT_EN.
module list_walker
  import list_walker_pkg::*;
#(
  parameter int unsigned ADDR_W  = MemoryAddrWidth,
  parameter int unsigned DATA_W  = MemoryDataWidth,
  parameter int unsigned LEN_W   = 8
`ifdef LIST_WALKER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] head_addr,
  input  logic [LEN_W-1:0]  max_len,
  output logic              busy,
  output logic              done,
  output logic              err_len,
`ifdef LIST_WALKER_TIMEOUT_EN
  output logic              err_timeout,
`endif
  output logic [LEN_W-1:0]  count,
  output logic              elem_valid,
  input  logic              elem_ready,
  output logic [ADDR_W-1:0] elem_value,
  output logic [ADDR_W-1:0] elem_addr,
  output logic [1:0]        mem_func,
  output logic              mem_execute,
  output logic [ADDR_W-1:0] mem_addr0,
  output logic [ADDR_W-1:0] mem_addr1,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data
);

  walk_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] link_q, link_d;
  logic [LEN_W-1:0]  limit_q, limit_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]  new_count;
  logic              err_len_q, err_len_d;
  logic              wait_seen_q, wait_seen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              elem_valid_q, elem_valid_d;
  logic [ADDR_W-1:0] elem_value_q, elem_value_d;
  logic [ADDR_W-1:0] elem_addr_q, elem_addr_d;
  logic              mem_execute_q, mem_execute_d;
  logic [1:0]        mem_func_q, mem_func_d;
  logic [ADDR_W-1:0] mem_addr0_q, mem_addr0_d;

`ifdef LIST_WALKER_TIMEOUT_EN
  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            err_timeout_q, err_timeout_d;
`endif

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    link_d       = link_q;
    limit_d      = limit_q;
    count_d      = count_q;
    err_len_d    = err_len_q;
    wait_seen_d  = wait_seen_q;
    elem_valid_d = elem_valid_q;
    elem_value_d = elem_value_q;
    elem_addr_d  = elem_addr_q;
    new_count    = (count_q == '1) ? count_q : count_q + LEN_W'(1);
`ifdef LIST_WALKER_TIMEOUT_EN
    tmr_d         = tmr_q;
    err_timeout_d = err_timeout_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d   = '0;
          err_len_d = 1'b0;
`ifdef LIST_WALKER_TIMEOUT_EN
          err_timeout_d = 1'b0;
`endif
          if (head_addr != ADDR_W'(Nil)) begin
            cur_d   = head_addr;
            limit_d = max_len;
            state_d = StIssue;
          end else begin
            state_d = StDone;
          end
        end
      end
      StIssue: begin
        wait_seen_d = 1'b0;
`ifdef LIST_WALKER_TIMEOUT_EN
        tmr_d = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        // The first WAIT cycle may still see ready from the previous request.
        wait_seen_d = 1'b1;
        if (wait_seen_q && mem_ready) begin
          link_d       = mem_data[DATA_W-1:ADDR_W];
          elem_value_d = mem_data[ADDR_W-1:0];
          elem_addr_d  = cur_q;
          elem_valid_d = 1'b1;
          state_d      = StEmit;
        end
`ifdef LIST_WALKER_TIMEOUT_EN
        else if (tmr_q == TmrW'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = StDone;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
`endif
      end
      StEmit: begin
        if (elem_ready) begin
          elem_valid_d = 1'b0;
          count_d      = new_count;
          if (link_q == ADDR_W'(Nil)) begin
            state_d = StDone;
          end else if (limit_q != '0 && new_count == limit_q) begin
            err_len_d = 1'b1;
            state_d   = StDone;
          end else begin
            cur_d   = link_q;
            state_d = StIssue;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Registered outputs follow the state being entered.
    mem_execute_d = (state_d == StIssue);
    mem_func_d    = mem_execute_d ? GetContents : 2'd0;
    mem_addr0_d   = mem_execute_d ? cur_d : '0;
    done_d        = (state_d == StDone);
    busy_d        = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cur_q         <= '0;
      link_q        <= '0;
      limit_q       <= '0;
      count_q       <= '0;
      err_len_q     <= 1'b0;
      wait_seen_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      elem_valid_q  <= 1'b0;
      elem_value_q  <= '0;
      elem_addr_q   <= '0;
      mem_execute_q <= 1'b0;
      mem_func_q    <= 2'd0;
      mem_addr0_q   <= '0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      link_q        <= link_d;
      limit_q       <= limit_d;
      count_q       <= count_d;
      err_len_q     <= err_len_d;
      wait_seen_q   <= wait_seen_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      elem_valid_q  <= elem_valid_d;
      elem_value_q  <= elem_value_d;
      elem_addr_q   <= elem_addr_d;
      mem_execute_q <= mem_execute_d;
      mem_func_q    <= mem_func_d;
      mem_addr0_q   <= mem_addr0_d;
    end
  end

`ifdef LIST_WALKER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      tmr_q         <= tmr_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign err_len     = err_len_q;
  assign count       = count_q;
  assign elem_valid  = elem_valid_q;
  assign elem_value  = elem_value_q;
  assign elem_addr   = elem_addr_q;
  assign mem_func    = mem_func_q;
  assign mem_execute = mem_execute_q;
  assign mem_addr0   = mem_addr0_q;
  assign mem_addr1   = '0;

endmodule

// File: tb/tb_list_walker.sv
// Directed bench for list_walker with a behavioural memory_unit and an element scoreboard.
module tb_list_walker;
  import list_walker_pkg::*;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 20;
  localparam int unsigned LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] head_addr = '0;
  logic [LEN_W-1:0]  max_len = '0;
  logic              busy, done, err_len;
  logic [LEN_W-1:0]  count;
  logic              elem_valid;
  logic              elem_ready = 1'b0;
  logic [ADDR_W-1:0] elem_value, elem_addr;
  logic [1:0]        mem_func;
  logic              mem_execute;
  logic [ADDR_W-1:0] mem_addr0, mem_addr1;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_data;
`ifdef LIST_WALKER_TIMEOUT_EN
  logic              err_timeout;
`endif

  always #5 clk = ~clk;

  list_walker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
`ifdef LIST_WALKER_TIMEOUT_EN
    ,
    .TIMEOUT(8)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .head_addr  (head_addr),
    .max_len    (max_len),
    .busy       (busy),
    .done       (done),
    .err_len    (err_len),
`ifdef LIST_WALKER_TIMEOUT_EN
    .err_timeout(err_timeout),
`endif
    .count      (count),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .elem_value (elem_value),
    .elem_addr  (elem_addr),
    .mem_func   (mem_func),
    .mem_execute(mem_execute),
    .mem_addr0  (mem_addr0),
    .mem_addr1  (mem_addr1),
    .mem_ready  (mem_ready),
    .mem_data   (mem_data)
  );

  // Memory model: ready drops one cycle late (stale ready in first WAIT cycle), then 2-cycle read.
  logic [DATA_W-1:0] mem [1024];
  logic              exec_d1 = 1'b0;
  logic [ADDR_W-1:0] addr_d1 = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  int                lat_cnt = 0;
  logic              rdy_q = 1'b1;
  logic [DATA_W-1:0] data_q = '1;
  logic              mem_stall = 1'b0;

  always @(posedge clk) begin
    exec_d1 <= mem_execute;
    addr_d1 <= mem_addr0;
    if (exec_d1) begin
      rdy_q    <= 1'b0;
      req_addr <= addr_d1;
      lat_cnt  <= 2;
    end else if (lat_cnt == 1) begin
      rdy_q   <= 1'b1;
      data_q  <= mem[req_addr];
      lat_cnt <= 0;
    end else if (lat_cnt > 1) begin
      lat_cnt <= lat_cnt - 1;
    end
  end

  assign mem_ready = rdy_q & ~mem_stall;
  assign mem_data  = data_q;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] value;
  } elem_t;

  elem_t q[$];
  int    passed = 0;
  int    total = 0;
  int    popped = 0;
  int    exec_total = 0;
  int    done_seen = 0;
  int    reads [1024];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (mem_execute) begin
      exec_total++;
      reads[mem_addr0]++;
      check("mem_func", 32'(mem_func), 32'(GetContents));
      check("mem_addr1", 32'(mem_addr1), 32'd0);
    end
    if (done) done_seen++;
    if (elem_valid) begin
      check("elem_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        check("elem_addr", 32'(elem_addr), 32'(q[0].addr));
        check("elem_value", 32'(elem_value), 32'(q[0].value));
        if (elem_ready) begin
          void'(q.pop_front());
          popped++;
        end
      end
    end
  end

  task automatic start_walk(input logic [ADDR_W-1:0] h, input logic [LEN_W-1:0] m);
    @(posedge clk);
    #1;
    start     = 1'b1;
    head_addr = h;
    max_len   = m;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] v);
    elem_t e;
    e.addr  = a;
    e.value = v;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc, base, b4, b7, b9, ds;
    bit ok;
    for (int i = 0; i < 1024; i++) begin
      mem[i]   = '0;
      reads[i] = 0;
    end
    mem[4] = {10'd7, 10'h011};
    mem[7] = {10'd9, 10'h022};
    mem[9] = {10'd0, 10'h033};
    mem[5] = {10'd5, 10'h0AA};

    // Reset values
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);
    check("rst_elem_valid", 32'(elem_valid), 32'd0);
    check("rst_mem_execute", 32'(mem_execute), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_mem_func", 32'(mem_func), 32'd0);
    check("rst_mem_addr0", 32'(mem_addr0), 32'd0);
    check("rst_elem_value", 32'(elem_value), 32'd0);
    check("rst_elem_addr", 32'(elem_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Chain walk
    elem_ready = 1'b1;
    base = exec_total;
    push(10'd4, 10'h011);
    push(10'd7, 10'h022);
    push(10'd9, 10'h033);
    start_walk(10'd4, 8'd0);
    wait_done(200, cyc);
    check("chain_done_seen", 32'(cyc > 0), 32'd1);
    check("chain_count", 32'(count), 32'd3);
    check("chain_err_len", 32'(err_len), 32'd0);
    check("chain_queue_empty", 32'(q.size()), 32'd0);
    check("chain_exec", 32'(exec_total - base), 32'd3);
    @(negedge clk);
    check("chain_done_pulse", 32'(done), 32'd0);
    check("chain_idle", 32'(busy), 32'd0);

    // NIL head
    base = exec_total;
    start_walk(10'd0, 8'd0);
    wait_done(20, cyc);
    check("nil_latency", 32'(cyc), 32'd1);
    check("nil_count", 32'(count), 32'd0);
    check("nil_err_len", 32'(err_len), 32'd0);
    @(negedge clk);
    check("nil_no_exec", 32'(exec_total - base), 32'd0);

    // Length limit
    b9 = reads[9];
    push(10'd4, 10'h011);
    push(10'd7, 10'h022);
    start_walk(10'd4, 8'd2);
    wait_done(200, cyc);
    check("len_done_seen", 32'(cyc > 0), 32'd1);
    check("len_count", 32'(count), 32'd2);
    check("len_err_len", 32'(err_len), 32'd1);
    check("len_cell9_unread", 32'(reads[9] - b9), 32'd0);
    check("len_queue_empty", 32'(q.size()), 32'd0);
    @(negedge clk);

    // Back-pressure: ready low 5 cycles per element
    elem_ready = 1'b0;
    b4 = reads[4];
    b7 = reads[7];
    b9 = reads[9];
    base = popped;
    push(10'd4, 10'h011);
    push(10'd7, 10'h022);
    push(10'd9, 10'h033);
    start_walk(10'd4, 8'd0);
    for (int e = 0; e < 3; e++) begin
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        ok = elem_valid;
      end
      check("bp_valid_seen", 32'(ok), 32'd1);
      repeat (5) @(posedge clk);
      #1 elem_ready = 1'b1;
      @(posedge clk);
      #1 elem_ready = 1'b0;
    end
    wait_done(50, cyc);
    check("bp_done_seen", 32'(cyc > 0), 32'd1);
    check("bp_count", 32'(count), 32'd3);
    check("bp_popped", 32'(popped - base), 32'd3);
    check("bp_reads4", 32'(reads[4] - b4), 32'd1);
    check("bp_reads7", 32'(reads[7] - b7), 32'd1);
    check("bp_reads9", 32'(reads[9] - b9), 32'd1);
    @(negedge clk);

    // Self-loop, then reset mid-walk
    elem_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(10'd5, 10'h0AA);
    base = popped;
    start_walk(10'd5, 8'd0);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (popped - base) >= 3;
    end
    check("loop_three_elems", 32'(ok), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    ds = done_seen;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_elem_valid", 32'(elem_valid), 32'd0);
    check("rstmid_mem_execute", 32'(mem_execute), 32'd0);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rstmid_no_done", 32'(done_seen - ds), 32'd0);
    check("rstmid_idle", 32'(busy), 32'd0);
    q.delete();

`ifdef LIST_WALKER_TIMEOUT_EN
    // Timeout: memory never ready
    mem_stall = 1'b1;
    start_walk(10'd4, 8'd0);
    wait_done(50, cyc);
    check("to_latency", 32'(cyc), 32'd10);
    check("to_err_timeout", 32'(err_timeout), 32'd1);
    check("to_count", 32'(count), 32'd0);
    check("to_err_len", 32'(err_len), 32'd0);
    @(negedge clk);
    mem_stall = 1'b0;
    push(10'd4, 10'h011);
    push(10'd7, 10'h022);
    push(10'd9, 10'h033);
    start_walk(10'd4, 8'd0);
    wait_done(200, cyc);
    check("to_clear_done", 32'(cyc > 0), 32'd1);
    check("to_clear_err_timeout", 32'(err_timeout), 32'd0);
    check("to_clear_count", 32'(count), 32'd3);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/list_walker.md
Name: list_walker

Overview:
- Command-driven list traversal engine sitting directly upstream of memory_unit; it is the sole driver of memory_unit's func/execute/addr0/addr1 request port.
- Given a head cell address, it repeatedly issues GET_CONTENTS, follows the link field of each cell and streams each cell's value field out over a valid/ready interface.
- Replaces the hard-coded pointer-chasing counter logic in the top level; the top level now only issues walk commands.

Parameters:
- ADDR_W, 10, cell address width; equals memory_addr_width.
- DATA_W, 20, cell width; must equal 2*ADDR_W (memory_data_width).
- LEN_W, 8, width of length limit and element counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  walk command strobe; sampled only in IDLE
- head_addr  in  ADDR_W  first cell address; 0 = NIL
- max_len  in  LEN_W  element limit; 0 = unlimited
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a walk ends
- err_len  out  1  valid with done: walk stopped by max_len with a non-NIL link remaining
- count  out  LEN_W  elements emitted in the last or current walk
- elem_valid  out  1  element available
- elem_ready  in  1  consumer accepts element
- elem_value  out  ADDR_W  value field, cell[ADDR_W-1:0]
- elem_addr  out  ADDR_W  address of the emitted cell
- mem_func  out  2  to memory_unit func; GET_CONTENTS while mem_execute is high, else 0
- mem_execute  out  1  to memory_unit execute
- mem_addr0  out  ADDR_W  to memory_unit addr0
- mem_addr1  out  ADDR_W  to memory_unit addr1; always 0
- mem_ready  in  1  from memory_unit is_ready
- mem_data  in  DATA_W  from memory_unit data_out

Behaviour:
- Cell layout: link = cell[DATA_W-1:ADDR_W], value = cell[ADDR_W-1:0]. Address 0 is NIL and is never read.
- Reset: state IDLE. busy, done, err_len, elem_valid, mem_execute all 0. count, mem_func, mem_addr0, mem_addr1, elem_value, elem_addr all 0.
- All outputs are registered.
- State IDLE:
  - start=1 and head_addr!=0: latch cur=head_addr, limit=max_len; clear count and err_len; go to ISSUE.
  - start=1 and head_addr=0: go to DONE, count=0.
  - start is ignored in all other states.
- State ISSUE: for exactly one cycle drive mem_execute=1, mem_func=GET_CONTENTS, mem_addr0=cur; go to WAIT.
- State WAIT:
  - mem_execute, mem_func and mem_addr0 return to 0.
  - mem_ready is ignored in the first WAIT cycle, because memory_unit's ready may still reflect the prior request.
  - On mem_ready=1 from the second cycle onward: latch mem_data, set elem_value, elem_addr=cur, elem_valid=1; go to EMIT.
- State EMIT:
  - Hold elem_valid and the element stable until elem_ready=1.
  - On the handshake: elem_valid=0, count=count+1 (saturates at all-ones).
  - Then, in priority order:
    - link==0: go to DONE.
    - limit!=0 and new count==limit: err_len=1, go to DONE.
    - Otherwise: cur=link, go to ISSUE.
- State DONE: done=1 for one cycle; count and err_len hold until the next accepted start; go to IDLE.
- Minimum latency per element: ISSUE 1 + WAIT ≥2 + EMIT ≥1, i.e. 4 cycles with elem_ready held high.
- Self-referencing or cyclic lists run until max_len is reached; with max_len=0 they run forever. The abort is reset only.
- Reset mid-walk returns to IDLE immediately, drops mem_execute and elem_valid, and emits no done.

Optional Feature:
- Macro: LIST_WALKER_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT, default 64, and output err_timeout (1 bit).
  - A WAIT-state cycle counter runs; if mem_ready has not arrived after TIMEOUT cycles, go to DONE with err_timeout=1.
  - err_timeout clears on the next accepted start.
- Undefined: no counter and no port; WAIT waits indefinitely.

Decomposition:
- Shared package/header memory_unit.vh holds GET_CONTENTS, memory_addr_width and memory_data_width; the block uses these and does not redefine them.
- Add a list_walker.vh holding the state encodings (IDLE, ISSUE, WAIT, EMIT, DONE) and the NIL constant.
- No sub-module, with one exception: the timeout counter may be a small wait_timer sub-module when LIST_WALKER_TIMEOUT_EN is defined.

Test Plan:
- Chain walk:
  - Memory: cell4={link 7, val 0x011}, cell7={9, 0x022}, cell9={0, 0x033}.
  - start head=4, max_len=0, elem_ready=1.
  - Expect: elements (4,0x011), (7,0x022), (9,0x033); done with count=3, err_len=0.
- NIL head: start head=0 -> done pulse 1 cycle later, count=0, no mem_execute ever asserted.
- Length limit: same chain, max_len=2 -> two elements emitted, done with count=2, err_len=1; cell9 never read.
- Back-pressure:
  - Chain walk with elem_ready low for 5 cycles at each element.
  - Expect: elem_value stable throughout; exactly one mem_execute per cell; no element lost or duplicated.
- Self-loop and reset:
  - cell5={5, 0x0AA}, start head=5, max_len=0.
  - Assert rst low after 3 elements -> busy=0, elem_valid=0, mem_execute=0 immediately; no done pulse.
- Timeout (LIST_WALKER_TIMEOUT_EN, TIMEOUT=8): hold mem_ready low -> done with err_timeout=1 on WAIT cycle 8; count=0.
